// File: rtl/turn_controller_pkg.sv
// Shared encodings for the game-sequencing logic: cell and result codes,
// turn FSM states, cursor direction codes and a saturating counter helper.
package turn_controller_pkg;

  localparam logic [1:0] CELL_O     = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_EMPTY = 2'b10;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_O    = 2'b01;
  localparam logic [1:0] RES_X    = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_CHECK = 3'd1,
    S_WRITE = 3'd2,
    S_EVAL  = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  // Cursor movement codes shared with the control unit.
  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] limit);
    logic [3:0] next_value;
    if (value < limit) begin
      next_value = value + 4'd1;
    end else begin
      next_value = limit;
    end
    return next_value;
  endfunction

endpackage

// File: rtl/turn_controller.sv
// Turn sequencing FSM: validates a place request, strobes one grid write,
// samples the win checker, alternates players and holds the game-over state.
module turn_controller
  import turn_controller_pkg::*;
#(
  parameter int NUM_CELLS    = 9,
  parameter bit FIRST_PLAYER = 1'b0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       place,
  input  logic       new_game,
  input  logic [3:0] cursor,
  input  logic [1:0] cell_state,
  input  logic [1:0] winner,
  output logic       wr_en,
  output logic [3:0] wr_addr,
  output logic [1:0] wr_value,
  output logic       clear_board,
  output logic       player,
  output logic [3:0] move_count,
  output logic       invalid_move,
  output logic       game_over,
  output logic [1:0] result
);

  localparam logic [3:0] CELL_LIMIT = 4'(NUM_CELLS);

  state_t     state_r, state_s;
  logic       player_r, player_s;
  logic [3:0] move_count_r, move_count_s;
  logic [3:0] wr_addr_r, wr_addr_s;
  logic [1:0] result_r, result_s;
  logic       wr_en_r, wr_en_s;
  logic       clear_board_r, clear_board_s;
  logic       invalid_move_r, invalid_move_s;
  logic       game_over_r, game_over_s;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r        <= S_WAIT;
      player_r       <= FIRST_PLAYER;
      move_count_r   <= 4'd0;
      wr_addr_r      <= 4'd0;
      result_r       <= RES_NONE;
      wr_en_r        <= 1'b0;
      clear_board_r  <= 1'b0;
      invalid_move_r <= 1'b0;
      game_over_r    <= 1'b0;
    end else begin
      state_r        <= state_s;
      player_r       <= player_s;
      move_count_r   <= move_count_s;
      wr_addr_r      <= wr_addr_s;
      result_r       <= result_s;
      wr_en_r        <= wr_en_s;
      clear_board_r  <= clear_board_s;
      invalid_move_r <= invalid_move_s;
      game_over_r    <= game_over_s;
    end
  end

  // Next-state and next-output decode; strobes are computed one cycle ahead.
  always_comb begin
    state_s        = state_r;
    player_s       = player_r;
    move_count_s   = move_count_r;
    wr_addr_s      = wr_addr_r;
    result_s       = result_r;
    wr_en_s        = 1'b0;
    clear_board_s  = 1'b0;
    invalid_move_s = 1'b0;

    if (new_game) begin
      clear_board_s = 1'b1;
      player_s      = FIRST_PLAYER;
      move_count_s  = 4'd0;
      result_s      = RES_NONE;
      state_s       = S_WAIT;
    end else begin
      case (state_r)
        S_WAIT: begin
          if (place) begin
            wr_addr_s = cursor;
            if (cursor >= CELL_LIMIT) begin
              invalid_move_s = 1'b1;
            end else begin
              state_s = S_CHECK;
            end
          end else begin
            state_s = S_WAIT;
          end
        end
        S_CHECK: begin
          if (cell_state != CELL_EMPTY) begin
            invalid_move_s = 1'b1;
            state_s        = S_WAIT;
          end else begin
            wr_en_s = 1'b1;
            state_s = S_WRITE;
          end
        end
        S_WRITE: begin
          move_count_s = sat_inc(move_count_r, CELL_LIMIT);
          state_s      = S_EVAL;
        end
        S_EVAL: begin
          // move_count_r already includes the piece just written
          if ((winner == RES_O) || (winner == RES_X)) begin
            result_s = winner;
            state_s  = S_OVER;
          end else if (move_count_r == CELL_LIMIT) begin
            result_s = RES_DRAW;
            state_s  = S_OVER;
          end else begin
            player_s = ~player_r;
            state_s  = S_WAIT;
          end
        end
        S_OVER: begin
          state_s = S_OVER;
        end
        default: begin
          state_s = S_WAIT;
        end
      endcase
    end

    game_over_s = (state_s == S_OVER);
  end

  // A new_game landing in the write cycle must not let the strobe reach the grid.
  assign wr_en        = wr_en_r & ~new_game;
  assign wr_addr      = wr_addr_r;
  assign wr_value     = {1'b0, player_r};
  assign clear_board  = clear_board_r;
  assign player       = player_r;
  assign move_count   = move_count_r;
  assign invalid_move = invalid_move_r;
  assign game_over    = game_over_r;
  assign result       = result_r;

endmodule

// File: tb/tb_turn_controller.sv
// Table-driven bench for turn_controller: each row is one clock cycle of
// inputs plus the outputs expected during that cycle, checked via a queue.
module tb_turn_controller;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       place = 1'b0;
  logic       new_game = 1'b0;
  logic [3:0] cursor = 4'd0;
  logic [1:0] cell_state = 2'b10;
  logic [1:0] winner = 2'b00;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [1:0] wr_value;
  logic       clear_board;
  logic       player;
  logic [3:0] move_count;
  logic       invalid_move;
  logic       game_over;
  logic [1:0] result;

  typedef struct packed {
    logic       we;
    logic [3:0] wa;
    logic [1:0] wv;
    logic       clr;
    logic       pl;
    logic [3:0] mc;
    logic       inv;
    logic       go;
    logic [1:0] res;
  } outs_t;

  typedef struct {
    logic       rn;
    logic       pl;
    logic       ng;
    logic [3:0] cur;
    logic [1:0] cs;
    logic [1:0] win;
    outs_t      exp;
  } vec_t;

  vec_t  vecs[$];
  outs_t exp_q[$];
  outs_t act;
  int    n_tests = 0;
  int    n_fail = 0;

  turn_controller #(.NUM_CELLS(9), .FIRST_PLAYER(1'b0)) dut (
    .clk(clk), .resetn(resetn), .place(place), .new_game(new_game),
    .cursor(cursor), .cell_state(cell_state), .winner(winner),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_value(wr_value),
    .clear_board(clear_board), .player(player), .move_count(move_count),
    .invalid_move(invalid_move), .game_over(game_over), .result(result)
  );

  always #5 clk = ~clk;

  assign act = {wr_en, wr_addr, wr_value, clear_board, player, move_count,
                invalid_move, game_over, result};

  function automatic outs_t o(input logic we, input logic [3:0] wa, input logic [1:0] wv,
                              input logic clr, input logic pl, input logic [3:0] mc,
                              input logic inv, input logic go, input logic [1:0] res);
    outs_t r;
    r = {we, wa, wv, clr, pl, mc, inv, go, res};
    return r;
  endfunction

  function automatic vec_t mkv(input logic rn, input logic pl, input logic ng,
                               input logic [3:0] cur, input logic [1:0] cs,
                               input logic [1:0] win, input outs_t e);
    vec_t v;
    v.rn = rn; v.pl = pl; v.ng = ng; v.cur = cur; v.cs = cs; v.win = win; v.exp = e;
    return v;
  endfunction

  task automatic add_row(input logic pl, input logic ng, input logic [3:0] cur,
                         input logic [1:0] cs, input logic [1:0] win, input outs_t e);
    vecs.push_back(mkv(1'b1, pl, ng, cur, cs, win, e));
  endtask

  // One accepted move by player p at cell c, starting from count m and prior address a.
  task automatic add_move(input logic [3:0] c, input logic p, input logic [3:0] m,
                          input logic [3:0] a, input logic [1:0] w);
    add_row(1'b1, 1'b0, c,    2'b10, 2'b00, o(1'b0, a, {1'b0, p}, 1'b0, p, m, 1'b0, 1'b0, 2'b00));
    add_row(1'b0, 1'b0, 4'd0, 2'b10, 2'b00, o(1'b0, c, {1'b0, p}, 1'b0, p, m, 1'b0, 1'b0, 2'b00));
    add_row(1'b0, 1'b0, 4'd0, 2'b10, 2'b00, o(1'b1, c, {1'b0, p}, 1'b0, p, m, 1'b0, 1'b0, 2'b00));
    add_row(1'b0, 1'b0, 4'd0, 2'b10, w,     o(1'b0, c, {1'b0, p}, 1'b0, p, m + 4'd1, 1'b0, 1'b0, 2'b00));
  endtask

  task automatic check(input string name, input int idx);
    outs_t e;
    e = exp_q.pop_front();
    n_tests++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s[%0d]: got we=%0b wa=%0d wv=%0d clr=%0b pl=%0b mc=%0d inv=%0b go=%0b res=%0d, expected we=%0b wa=%0d wv=%0d clr=%0b pl=%0b mc=%0d inv=%0b go=%0b res=%0d",
               name, idx, act.we, act.wa, act.wv, act.clr, act.pl, act.mc, act.inv, act.go, act.res,
               e.we, e.wa, e.wv, e.clr, e.pl, e.mc, e.inv, e.go, e.res);
    end
  endtask

  task automatic apply(input vec_t v, input string name, input int idx);
    @(negedge clk);
    resetn     = v.rn;
    place      = v.pl;
    new_game   = v.ng;
    cursor     = v.cur;
    cell_state = v.cs;
    winner     = v.win;
    exp_q.push_back(v.exp);
    #1;
    check(name, idx);
  endtask

  initial begin
    outs_t zero;
    zero = o(1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0);

    // Valid move by O at cell 4.
    add_move(4'd4, 1'b0, 4'd0, 4'd0, 2'b00);
    // Occupied cell: rejected, X keeps the turn.
    add_row(1'b1, 1'b0, 4'd4, 2'b10, 2'b00, o(1'b0, 4'd4, 2'd1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 2'd0));
    add_row(1'b0, 1'b0, 4'd0, 2'b01, 2'b00, o(1'b0, 4'd4, 2'd1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 2'd0));
    add_row(1'b0, 1'b0, 4'd0, 2'b10, 2'b00, o(1'b0, 4'd4, 2'd1, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 2'd0));
    add_row(1'b0, 1'b0, 4'd0, 2'b10, 2'b00, o(1'b0, 4'd4, 2'd1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 2'd0));
    // Out-of-range cursor.
    add_row(1'b1, 1'b0, 4'd9, 2'b10, 2'b00, o(1'b0, 4'd4, 2'd1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 2'd0));
    add_row(1'b0, 1'b0, 4'd0, 2'b10, 2'b00, o(1'b0, 4'd9, 2'd1, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 2'd0));
    // Accepted place, then new_game during the write cycle.
    add_row(1'b1, 1'b0, 4'd5, 2'b10, 2'b00, o(1'b0, 4'd9, 2'd1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 2'd0));
    add_row(1'b0, 1'b0, 4'd0, 2'b10, 2'b00, o(1'b0, 4'd5, 2'd1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 2'd0));
    add_row(1'b0, 1'b1, 4'd0, 2'b10, 2'b00, o(1'b0, 4'd5, 2'd1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 2'd0));
    add_row(1'b0, 1'b0, 4'd0, 2'b10, 2'b00, o(1'b0, 4'd5, 2'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0));
    // O wins on 0,1,2 against X on 3,4.
    add_move(4'd0, 1'b0, 4'd0, 4'd5, 2'b00);
    add_move(4'd3, 1'b1, 4'd1, 4'd0, 2'b00);
    add_move(4'd1, 1'b0, 4'd2, 4'd3, 2'b00);
    add_move(4'd4, 1'b1, 4'd3, 4'd1, 2'b00);
    add_move(4'd2, 1'b0, 4'd4, 4'd4, 2'b01);
    add_row(1'b1, 1'b0, 4'd7, 2'b10, 2'b00, o(1'b0, 4'd2, 2'd0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b1, 2'd1));
    add_row(1'b1, 1'b0, 4'd8, 2'b10, 2'b00, o(1'b0, 4'd2, 2'd0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b1, 2'd1));
    add_row(1'b0, 1'b1, 4'd0, 2'b10, 2'b00, o(1'b0, 4'd2, 2'd0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b1, 2'd1));
    add_row(1'b0, 1'b0, 4'd0, 2'b10, 2'b00, o(1'b0, 4'd2, 2'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0));
    // Full board with no winner reported: forced draw.
    for (int k = 0; k < 9; k++) begin
      add_move(4'(k), 1'(k % 2), 4'(k), (k == 0) ? 4'd2 : 4'(k - 1), 2'b00);
    end
    add_row(1'b1, 1'b0, 4'd3, 2'b10, 2'b00, o(1'b0, 4'd8, 2'd0, 1'b0, 1'b0, 4'd9, 1'b0, 1'b1, 2'd3));
    // Restart, place dropped in CHECK, then reset in the middle of EVAL.
    add_row(1'b0, 1'b1, 4'd0, 2'b10, 2'b00, o(1'b0, 4'd8, 2'd0, 1'b0, 1'b0, 4'd9, 1'b0, 1'b1, 2'd3));
    add_row(1'b0, 1'b0, 4'd0, 2'b10, 2'b00, o(1'b0, 4'd8, 2'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0));
    add_row(1'b1, 1'b0, 4'd3, 2'b10, 2'b00, o(1'b0, 4'd8, 2'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0));
    add_row(1'b1, 1'b0, 4'd6, 2'b10, 2'b00, o(1'b0, 4'd3, 2'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0));
    add_row(1'b0, 1'b0, 4'd0, 2'b10, 2'b00, o(1'b1, 4'd3, 2'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0));
    vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 4'd0, 2'b10, 2'b01,
                       o(1'b0, 4'd3, 2'd0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 2'd0)));
    add_row(1'b0, 1'b0, 4'd0, 2'b10, 2'b00, zero);

    // Hold reset for two edges, then check the reset state.
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    apply(mkv(1'b1, 1'b0, 1'b0, 4'd0, 2'b10, 2'b00, zero), "reset", 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], "row", i);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
